// File: rtl/tipi_nib_master_if.sv
// tipi_nib_master_if: command/response handshake plus the TIPI nibble-bus pins.
//   master modport - the nibble-bus initiator (tipi_nib_master) view.
//   slave modport  - the environment view: it issues commands and drives r_nib_i.
// Signals:
//   cmd_valid/cmd_ready/cmd_reg/cmd_wdata : single-register command request
//   rsp_valid/rsp_data/rsp_err            : transaction completion and read data
//   r_clk_o/r_nibrst_o/r_nib_o/r_nib_oe   : nibble bus driven by the master
//   r_nib_i                               : nibble bus value seen by the master
interface tipi_nib_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       r_clk_o;
  logic       r_nibrst_o;
  logic [3:0] r_nib_o;
  logic       r_nib_oe;
  logic [3:0] r_nib_i;

  modport master (
    input  cmd_valid, cmd_reg, cmd_wdata, r_nib_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output r_clk_o, r_nibrst_o, r_nib_o, r_nib_oe
  );

  modport slave (
    output cmd_valid, cmd_reg, cmd_wdata, r_nib_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  r_clk_o, r_nibrst_o, r_nib_o, r_nib_oe
  );
endinterface

// File: rtl/tipi_nib_master.sv
// tipi_nib_master: Pi-side initiator for the TIPI 4-bit nibble bus.
// Turns one accepted command into a nibble-bus transaction: a sequence-reset
// pulse carrying the register select, then three r_clk pulses. Writes (RD/RC)
// drive the data high/low nibbles; reads (TD/TC) turn the bus around and sample
// the slave's high/low nibbles at the end of the P1/P2 low phases.
// Ports:
//   clk      - system clock
//   r_reset  - synchronous active-high reset
//   bus      - tipi_nib_master_if.master: command, response and nibble-bus pins
// Parameter CLK_DIV: clk cycles per r_clk half-period (>= 1, >= 2 when the
// double-sample option is enabled).
// Optional build macro TIPI_NIB_DBL_SAMPLE_EN: each read nibble is also sampled
// in the first cycle of its low phase; a disagreement sets rsp_err for that
// response. Without the macro rsp_err is tied low.
module tipi_nib_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input logic              clk,
  input logic              r_reset,
  tipi_nib_master_if.master bus
);

  typedef enum logic [3:0] {
    StIdle, StNrstHi, StNrstLo, StP0Hi, StP0Lo, StP1Hi, StP1Lo, StP2Hi, StP2Lo, StDone
  } state_e;

  localparam int unsigned    CntW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      reg_q, reg_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [3:0]      hi_q, hi_d;
  logic [7:0]      data_q, data_d;
  logic            rclk_q, rclk_d;
  logic            nrst_q, nrst_d;
  logic            oe_q, oe_d;
  logic [3:0]      nib_q, nib_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic            accept;
  logic            phase_end;
  logic [3:0]      sel_d;

`ifdef TIPI_NIB_DBL_SAMPLE_EN
  logic [3:0] first_q, first_d;
  logic       err_q, err_d;
`endif

  assign accept    = bus.cmd_valid && ready_q;
  assign phase_end = (cnt_q == CntLast);
  assign sel_d     = {2'b00, reg_d};

  // Sequencing: each bus phase lasts CLK_DIV cycles, then moves to the next one.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle, StDone: state_d = accept ? StNrstHi : StIdle;
      StNrstHi:       if (phase_end) state_d = StNrstLo;
      StNrstLo:       if (phase_end) state_d = StP0Hi;
      StP0Hi:         if (phase_end) state_d = StP0Lo;
      StP0Lo:         if (phase_end) state_d = StP1Hi;
      StP1Hi:         if (phase_end) state_d = StP1Lo;
      StP1Lo:         if (phase_end) state_d = StP2Hi;
      StP2Hi:         if (phase_end) state_d = StP2Lo;
      StP2Lo:         if (phase_end) state_d = StDone;
      default:        state_d = StIdle;
    endcase
    if (state_q != StIdle && state_q != StDone && !phase_end) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (accept) begin
      reg_d   = bus.cmd_reg;
      wdata_d = bus.cmd_wdata;
    end
  end

  // Read sampling. The high nibble is parked in hi_q so rsp_data only changes
  // together with the response.
  always_comb begin
    hi_d   = hi_q;
    data_d = data_q;
    if (!reg_q[1] && phase_end) begin
      if (state_q == StP1Lo) hi_d = bus.r_nib_i;
      if (state_q == StP2Lo) data_d = {hi_q, bus.r_nib_i};
    end
  end

`ifdef TIPI_NIB_DBL_SAMPLE_EN
  always_comb begin
    first_d = first_q;
    err_d   = err_q;
    if (!reg_q[1] && (state_q == StP1Lo || state_q == StP2Lo)) begin
      if (cnt_q == '0) first_d = bus.r_nib_i;
      if (phase_end && (first_q != bus.r_nib_i)) err_d = 1'b1;
    end
    if (accept) err_d = 1'b0;
  end
`endif

  // Bus pins are decoded from the next state so they are registered alongside it.
  always_comb begin
    rclk_d  = 1'b0;
    nrst_d  = 1'b0;
    oe_d    = 1'b0;
    nib_d   = 4'h0;
    ready_d = 1'b0;
    valid_d = 1'b0;
    unique case (state_d)
      StIdle: ready_d = 1'b1;
      StDone: begin
        ready_d = 1'b1;
        valid_d = 1'b1;
      end
      StNrstHi: begin
        nrst_d = 1'b1;
        oe_d   = 1'b1;
        nib_d  = sel_d;
      end
      StNrstLo: begin
        oe_d  = 1'b1;
        nib_d = sel_d;
      end
      StP0Hi: begin
        rclk_d = 1'b1;
        oe_d   = 1'b1;
        nib_d  = sel_d;
      end
      StP0Lo, StP1Hi: begin
        rclk_d = (state_d == StP1Hi);
        oe_d   = reg_d[1];
        nib_d  = reg_d[1] ? wdata_d[7:4] : sel_d;
      end
      StP1Lo, StP2Hi, StP2Lo: begin
        rclk_d = (state_d == StP2Hi);
        oe_d   = reg_d[1];
        nib_d  = reg_d[1] ? wdata_d[3:0] : sel_d;
      end
      default: ready_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      reg_q   <= 2'b00;
      wdata_q <= 8'h00;
      hi_q    <= 4'h0;
      data_q  <= 8'h00;
      rclk_q  <= 1'b0;
      nrst_q  <= 1'b0;
      oe_q    <= 1'b0;
      nib_q   <= 4'h0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      rclk_q  <= rclk_d;
      nrst_q  <= nrst_d;
      oe_q    <= oe_d;
      nib_q   <= nib_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

`ifdef TIPI_NIB_DBL_SAMPLE_EN
  always_ff @(posedge clk) begin
    if (r_reset) begin
      first_q <= 4'h0;
      err_q   <= 1'b0;
    end else begin
      first_q <= first_d;
      err_q   <= err_d;
    end
  end
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.cmd_ready  = ready_q;
  assign bus.rsp_valid  = valid_q;
  assign bus.rsp_data   = data_q;
  assign bus.r_clk_o    = rclk_q;
  assign bus.r_nibrst_o = nrst_q;
  assign bus.r_nib_o    = nib_q;
  assign bus.r_nib_oe   = oe_q;

endmodule

// File: tb/tb_tipi_nib_master.sv
// tb_tipi_nib_master: self-checking bench for tipi_nib_master (CLK_DIV=2).
// A transaction is described by its register, write data, the byte the slave
// returns on reads and whether the high read nibble glitches early in its phase.
// The expected bus waveform is derived cycle by cycle from the phase number.
module tb_tipi_nib_master;
  localparam int unsigned Div = 2;
`ifdef TIPI_NIB_DBL_SAMPLE_EN
  localparam bit DblEn = 1'b1;
`else
  localparam bit DblEn = 1'b0;
`endif

  typedef struct {
    logic [1:0] r;
    logic [7:0] w;
    logic [7:0] rd;
    bit         flip;
  } vec_t;

  logic clk = 1'b0;
  logic r_reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] last_rd = 8'h00;

  tipi_nib_master_if bus_if ();

  tipi_nib_master #(.CLK_DIV(Div)) dut (
    .clk    (clk),
    .r_reset(r_reset),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (bus_if.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_idle", bus_if.cmd_ready, 1'b1);
  endtask

  // One full transaction, checked every cycle from NRST_HI through the cycle after DONE.
  task automatic run_txn(input logic [1:0] r, input logic [7:0] w, input logic [7:0] rd,
                         input bit flip);
    bit         wr = r[1];
    logic [3:0] sel = {2'b00, r};
    int         ph;
    logic [3:0] enib;
    logic [7:0] edata;
    wait_ready();
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_reg   = r;
    bus_if.cmd_wdata = w;
    bus_if.r_nib_i   = 4'($urandom);
    edata = wr ? last_rd : rd;
    for (int k = 0; k <= 8 * Div + 1; k++) begin
      @(negedge clk);
      ph = k / Div;
      if (k < 8 * Div) begin
        chk("r_clk", bus_if.r_clk_o, (ph == 2 || ph == 4 || ph == 6));
        chk("nibrst", bus_if.r_nibrst_o, (ph == 0));
        chk("oe", bus_if.r_nib_oe, wr ? 1'b1 : (ph < 3));
        chk("busy_ready", bus_if.cmd_ready, 1'b0);
        chk("early_valid", bus_if.rsp_valid, 1'b0);
        chk("data_hold", bus_if.rsp_data, last_rd);
        enib = (ph < 3) ? sel : (ph < 5) ? w[7:4] : w[3:0];
        if (wr || ph < 3) chk("nib", bus_if.r_nib_o, enib);
      end else if (k == 8 * Div) begin
        chk("done_valid", bus_if.rsp_valid, 1'b1);
        chk("done_ready", bus_if.cmd_ready, 1'b1);
        chk("done_oe", bus_if.r_nib_oe, 1'b0);
        chk("done_clk", bus_if.r_clk_o, 1'b0);
        chk("rsp_data", bus_if.rsp_data, edata);
        chk("rsp_err", bus_if.rsp_err, (DblEn && flip && !wr));
        last_rd = edata;
      end else begin
        chk("post_valid", bus_if.rsp_valid, 1'b0);
        chk("post_oe", bus_if.r_nib_oe, 1'b0);
        chk("post_data", bus_if.rsp_data, last_rd);
      end
      // Command inputs change after accept to prove they were latched.
      if (k == 0) begin
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_reg   = 2'($urandom);
        bus_if.cmd_wdata = 8'($urandom);
      end
      if (!wr) begin
        if (k == 5 * Div) bus_if.r_nib_i = flip ? (rd[7:4] ^ 4'hf) : rd[7:4];
        if (k == 5 * Div + 1) bus_if.r_nib_i = rd[7:4];
        if (k == 7 * Div) bus_if.r_nib_i = rd[3:0];
      end
    end
  endtask

  vec_t tbl[7];

  initial begin
    int np;
    int pos[2];
    int extra;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_reg   = 2'd0;
    bus_if.cmd_wdata = 8'h00;
    bus_if.r_nib_i   = 4'h0;

    tbl[0] = '{r: 2'd2, w: 8'ha5, rd: 8'h00, flip: 1'b0};
    tbl[1] = '{r: 2'd3, w: 8'h6b, rd: 8'h00, flip: 1'b0};
    tbl[2] = '{r: 2'd0, w: 8'h00, rd: 8'ha5, flip: 1'b0};
    tbl[3] = '{r: 2'd1, w: 8'hff, rd: 8'h3c, flip: 1'b0};
    tbl[4] = '{r: 2'd0, w: 8'h00, rd: 8'h81, flip: 1'b1};
    tbl[5] = '{r: 2'd2, w: 8'h00, rd: 8'h00, flip: 1'b0};
    tbl[6] = '{r: 2'd3, w: 8'hff, rd: 8'h00, flip: 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_clk", bus_if.r_clk_o, 1'b0);
    chk("rst_nibrst", bus_if.r_nibrst_o, 1'b0);
    chk("rst_oe", bus_if.r_nib_oe, 1'b0);
    chk("rst_nib", bus_if.r_nib_o, 4'h0);
    chk("rst_ready", bus_if.cmd_ready, 1'b1);
    chk("rst_valid", bus_if.rsp_valid, 1'b0);
    chk("rst_data", bus_if.rsp_data, 8'h00);
    chk("rst_err", bus_if.rsp_err, 1'b0);
    r_reset = 1'b0;

    foreach (tbl[i]) run_txn(tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].flip);

    // Abort a write in P1_HI, then a read must still complete.
    wait_ready();
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_reg   = 2'd3;
    bus_if.cmd_wdata = 8'h3c;
    for (int k = 0; k <= 4 * Div; k++) begin
      @(negedge clk);
      if (k == 0) bus_if.cmd_valid = 1'b0;
    end
    chk("abort_in_p1hi", bus_if.r_clk_o, 1'b1);
    r_reset = 1'b1;
    @(negedge clk);
    chk("abort_clk", bus_if.r_clk_o, 1'b0);
    chk("abort_nibrst", bus_if.r_nibrst_o, 1'b0);
    chk("abort_oe", bus_if.r_nib_oe, 1'b0);
    chk("abort_nib", bus_if.r_nib_o, 4'h0);
    chk("abort_ready", bus_if.cmd_ready, 1'b1);
    chk("abort_valid", bus_if.rsp_valid, 1'b0);
    chk("abort_data", bus_if.rsp_data, 8'h00);
    last_rd = 8'h00;
    r_reset = 1'b0;
    extra = 0;
    for (int k = 0; k < 8 * Div + 2; k++) begin
      @(negedge clk);
      if (bus_if.rsp_valid === 1'b1) extra++;
    end
    chk("abort_no_rsp", 8'(extra), 8'd0);
    run_txn(2'd1, 8'h00, 8'h5e, 1'b0);

    // Back-to-back: cmd_valid held high for two transactions.
    wait_ready();
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_reg   = 2'd3;
    bus_if.cmd_wdata = 8'h99;
    np = 0;
    pos[0] = 0;
    pos[1] = 0;
    for (int c = 1; c < 80 && np < 2; c++) begin
      @(negedge clk);
      if (bus_if.rsp_valid === 1'b1) begin
        pos[np] = c;
        np++;
        if (np == 2) bus_if.cmd_valid = 1'b0;
      end
    end
    chk("b2b_count", 8'(np), 8'd2);
    chk("b2b_first", 8'(pos[0]), 8'(8 * Div + 1));
    chk("b2b_gap", 8'(pos[1] - pos[0]), 8'(8 * Div + 1));
    extra = 0;
    for (int k = 0; k < 8 * Div + 3; k++) begin
      @(negedge clk);
      if (bus_if.rsp_valid === 1'b1) extra++;
    end
    chk("b2b_no_third", 8'(extra), 8'd0);

    // Randomized transactions against the phase-level model.
    for (int i = 0; i < 24; i++) begin
      run_txn(2'($urandom), 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
